// File: rtl/vend_txn_ctrl.sv
// Vending machine transaction sequencer: coin credit, product selection, dispense and change handshakes.
// Optional per-product stock tracking is enabled by defining VEND_INVENTORY_EN.
//
// state    | meaning
// IDLE     | no credit, waiting for a coin
// CREDIT   | credit held, waiting for selection, more coins, cancel or timeout
// DISPENSE | disp_req asserted, waiting for disp_done
// CHANGE   | returning remaining credit one coin at a time
module vend_txn_ctrl #(
   parameter int CREDIT_W    = 6,
   parameter int CREDIT_MAX  = 40,
   parameter int PRICE_NEWS  = 5,
   parameter int PRICE_BAR   = 10,
   parameter int PRICE_JUICE = 15,
   parameter int TIMEOUT_CYC = 1000,
   parameter int STOCK_INIT  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_valid,
   input  logic [4:0]          coin_value,
   output logic                coin_accept,
   output logic                coin_reject,
   input  logic                sel_valid,
   input  logic [1:0]          sel_product,
   output logic                sel_nack,
   input  logic                cancel,
   output logic                disp_req,
   output logic [1:0]          disp_product,
   input  logic                disp_done,
   output logic                chg_valid,
   output logic [4:0]          chg_coin,
   input  logic                chg_ack,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic [2:0]          sold_out
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CREDIT   = 2'd1;
   localparam logic [1:0] ST_DISPENSE = 2'd2;
   localparam logic [1:0] ST_CHANGE   = 2'd3;

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0]    TMO_LOAD   = TMO_W'(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0]    TMO_ONE    = TMO_W'(1);
   localparam logic [CREDIT_W:0]   CREDIT_CAP = (CREDIT_W + 1)'(CREDIT_MAX);
   localparam logic [CREDIT_W-1:0] CREDIT_10  = CREDIT_W'(10);

   logic [1:0]          state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                coin_accept_q, coin_accept_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sel_nack_q, sel_nack_d;
   logic                disp_req_q, disp_req_d;
   logic [1:0]          disp_product_q, disp_product_d;
   logic                chg_valid_q, chg_valid_d;
   logic [4:0]          chg_coin_q, chg_coin_d;
   logic                busy_q, busy_d;

   logic                coin_legal;
   logic                coin_ok;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] sel_price;
   logic                sel_code_ok;
   logic                sel_in_stock;
   logic                sel_ok;

   assign coin_legal = (coin_value == 5'd5) || (coin_value == 5'd10) || (coin_value == 5'd20);
   assign credit_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value);
   assign coin_ok    = coin_legal && (credit_sum <= CREDIT_CAP);

   always_comb begin
      sel_price   = '0;
      sel_code_ok = 1'b1;
      case (sel_product)
         2'b01:   sel_price = CREDIT_W'(PRICE_NEWS);
         2'b10:   sel_price = CREDIT_W'(PRICE_BAR);
         2'b11:   sel_price = CREDIT_W'(PRICE_JUICE);
         default: sel_code_ok = 1'b0;
      endcase
   end

   assign sel_ok = sel_code_ok && sel_in_stock && (credit_q >= sel_price);

`ifdef VEND_INVENTORY_EN
   // Index 0 newspaper, 1 bar, 2 juice.
   logic [2:0][2:0] stock_q, stock_d;

   always_comb begin
      sel_in_stock = 1'b0;
      case (sel_product)
         2'b01:   sel_in_stock = (stock_q[0] != 3'd0);
         2'b10:   sel_in_stock = (stock_q[1] != 3'd0);
         2'b11:   sel_in_stock = (stock_q[2] != 3'd0);
         default: sel_in_stock = 1'b0;
      endcase
   end

   always_comb begin
      stock_d = stock_q;
      if ((state_q == ST_DISPENSE) && disp_done) begin
         case (disp_product_q)
            2'b01:   if (stock_q[0] != 3'd0) stock_d[0] = stock_q[0] - 3'd1;
            2'b10:   if (stock_q[1] != 3'd0) stock_d[1] = stock_q[1] - 3'd1;
            2'b11:   if (stock_q[2] != 3'd0) stock_d[2] = stock_q[2] - 3'd1;
            default: stock_d = stock_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stock_q <= {3{3'(STOCK_INIT)}};
      end else begin
         stock_q <= stock_d;
      end
   end

   assign sold_out = {stock_q[2] == 3'd0, stock_q[1] == 3'd0, stock_q[0] == 3'd0};
`else
   logic [2:0] stock_unused;
   assign stock_unused = 3'(STOCK_INIT);
   assign sel_in_stock = 1'b1;
   assign sold_out     = 3'b000;
`endif

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      tmo_d          = tmo_q;
      disp_product_d = disp_product_q;
      coin_accept_d  = 1'b0;
      coin_reject_d  = 1'b0;
      sel_nack_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (coin_valid) begin
               if (coin_ok) begin
                  coin_accept_d = 1'b1;
                  credit_d      = credit_sum[CREDIT_W-1:0];
                  tmo_d         = TMO_LOAD;
                  state_d       = ST_CREDIT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         ST_CREDIT: begin
            if (cancel) begin
               coin_reject_d = coin_valid;
               state_d       = ST_CHANGE;
            end else if (sel_valid) begin
               coin_reject_d = coin_valid;
               tmo_d         = TMO_LOAD;
               if (sel_ok) begin
                  credit_d       = credit_q - sel_price;
                  disp_product_d = sel_product;
                  state_d        = ST_DISPENSE;
               end else begin
                  sel_nack_d = 1'b1;
               end
            end else if (coin_valid && coin_ok) begin
               coin_accept_d = 1'b1;
               credit_d      = credit_sum[CREDIT_W-1:0];
               tmo_d         = TMO_LOAD;
            end else begin
               // A rejected coin does not count as activity for the refund timer.
               coin_reject_d = coin_valid;
               if (tmo_q <= TMO_ONE) begin
                  state_d = ST_CHANGE;
               end else begin
                  tmo_d = tmo_q - TMO_ONE;
               end
            end
         end
         ST_DISPENSE: begin
            coin_reject_d = coin_valid;
            if (disp_done) begin
               disp_product_d = 2'b00;
               state_d        = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
         end
         default: begin
            coin_reject_d = coin_valid;
            if (chg_ack) begin
               credit_d = credit_q - CREDIT_W'(chg_coin_q);
               if (credit_d == '0) state_d = ST_IDLE;
            end
         end
      endcase

      disp_req_d  = (state_d == ST_DISPENSE);
      chg_valid_d = (state_d == ST_CHANGE);
      chg_coin_d  = 5'd0;
      if (chg_valid_d) chg_coin_d = (credit_d >= CREDIT_10) ? 5'd10 : 5'd5;
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         tmo_q          <= '0;
         coin_accept_q  <= 1'b0;
         coin_reject_q  <= 1'b0;
         sel_nack_q     <= 1'b0;
         disp_req_q     <= 1'b0;
         disp_product_q <= 2'b00;
         chg_valid_q    <= 1'b0;
         chg_coin_q     <= 5'd0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         tmo_q          <= tmo_d;
         coin_accept_q  <= coin_accept_d;
         coin_reject_q  <= coin_reject_d;
         sel_nack_q     <= sel_nack_d;
         disp_req_q     <= disp_req_d;
         disp_product_q <= disp_product_d;
         chg_valid_q    <= chg_valid_d;
         chg_coin_q     <= chg_coin_d;
         busy_q         <= busy_d;
      end
   end

   assign coin_accept  = coin_accept_q;
   assign coin_reject  = coin_reject_q;
   assign sel_nack     = sel_nack_q;
   assign disp_req     = disp_req_q;
   assign disp_product = disp_product_q;
   assign chg_valid    = chg_valid_q;
   assign chg_coin     = chg_coin_q;
   assign credit       = credit_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: purchase, refusal, overflow, timeout, reset and stock scenarios.
// Stock expectations follow VEND_INVENTORY_EN when it is defined for the build.
module tb_vend_txn_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       coin_valid = 1'b0;
   logic [4:0] coin_value = 5'd0;
   logic       coin_accept, coin_reject;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_product = 2'b00;
   logic       sel_nack;
   logic       cancel = 1'b0;
   logic       disp_req;
   logic [1:0] disp_product;
   logic       disp_done = 1'b0;
   logic       chg_valid;
   logic [4:0] chg_coin;
   logic       chg_ack = 1'b0;
   logic [5:0] credit;
   logic       busy;
   logic [2:0] sold_out;

   int n_checks = 0;
   int n_fail   = 0;

   vend_txn_ctrl #(.STOCK_INIT(1)) dut (
      .clk(clk), .reset(reset),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .coin_accept(coin_accept), .coin_reject(coin_reject),
      .sel_valid(sel_valid), .sel_product(sel_product), .sel_nack(sel_nack),
      .cancel(cancel),
      .disp_req(disp_req), .disp_product(disp_product), .disp_done(disp_done),
      .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ack(chg_ack),
      .credit(credit), .busy(busy), .sold_out(sold_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic insert_coin(input logic [4:0] v);
      coin_valid = 1'b1;
      coin_value = v;
      tick();
      coin_valid = 1'b0;
      coin_value = 5'd0;
   endtask

   task automatic select(input logic [1:0] p);
      sel_valid   = 1'b1;
      sel_product = p;
      tick();
      sel_valid   = 1'b0;
      sel_product = 2'b00;
   endtask

   task automatic ack_change();
      chg_ack = 1'b1;
      tick();
      chg_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0d expected 0", busy); end
      n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL rst_credit: got %0d expected 0", credit); end
      n_checks++; if ({coin_accept, coin_reject, sel_nack, disp_req, chg_valid} !== 5'b0) begin
         n_fail++; $display("FAIL rst_pulses: got %b expected 00000", {coin_accept, coin_reject, sel_nack, disp_req, chg_valid}); end
      n_checks++; if (sold_out !== 3'b000) begin n_fail++; $display("FAIL rst_sold_out: got %b expected 000", sold_out); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_purchase();
      int hi;
      insert_coin(5'd20);
      n_checks++; if (coin_accept !== 1'b1) begin n_fail++; $display("FAIL buy_accept: got %0d expected 1", coin_accept); end
      n_checks++; if (credit !== 6'd20) begin n_fail++; $display("FAIL buy_credit: got %0d expected 20", credit); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL buy_busy: got %0d expected 1", busy); end
      tick();
      n_checks++; if (coin_accept !== 1'b0) begin n_fail++; $display("FAIL buy_accept_pulse: got %0d expected 0", coin_accept); end
      select(2'b11);
      n_checks++; if (credit !== 6'd5) begin n_fail++; $display("FAIL buy_credit_after_sel: got %0d expected 5", credit); end
      hi = 0;
      for (int i = 0; i < 3; i++) begin
         if (disp_req === 1'b1) hi++;
         n_checks++; if (disp_product !== 2'b11) begin n_fail++; $display("FAIL buy_product: got %b expected 11", disp_product); end
         if (i == 2) disp_done = 1'b1;
         tick();
      end
      disp_done = 1'b0;
      n_checks++; if (hi != 3) begin n_fail++; $display("FAIL buy_req_cycles: got %0d expected 3", hi); end
      n_checks++; if (disp_req !== 1'b0) begin n_fail++; $display("FAIL buy_req_drop: got %0d expected 0", disp_req); end
      n_checks++; if (chg_valid !== 1'b1 || chg_coin !== 5'd5) begin
         n_fail++; $display("FAIL buy_change: got valid %0d coin %0d expected valid 1 coin 5", chg_valid, chg_coin); end
      ack_change();
      n_checks++; if (credit !== 6'd0 || chg_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL buy_idle: got credit %0d valid %0d busy %0d expected 0 0 0", credit, chg_valid, busy); end
   endtask

   task automatic test_nack_cancel();
      insert_coin(5'd5);
      insert_coin(5'd5);
      n_checks++; if (credit !== 6'd10) begin n_fail++; $display("FAIL nack_credit_in: got %0d expected 10", credit); end
      coin_valid = 1'b1;
      coin_value = 5'd5;
      select(2'b11);
      coin_valid = 1'b0;
      n_checks++; if (sel_nack !== 1'b1) begin n_fail++; $display("FAIL nack_pulse: got %0d expected 1", sel_nack); end
      n_checks++; if (coin_reject !== 1'b1) begin n_fail++; $display("FAIL nack_coin_same_cycle: got %0d expected 1", coin_reject); end
      n_checks++; if (credit !== 6'd10 || disp_req !== 1'b0) begin
         n_fail++; $display("FAIL nack_hold: got credit %0d req %0d expected 10 0", credit, disp_req); end
      tick();
      n_checks++; if (sel_nack !== 1'b0) begin n_fail++; $display("FAIL nack_pulse_end: got %0d expected 0", sel_nack); end
      select(2'b00);
      n_checks++; if (sel_nack !== 1'b1) begin n_fail++; $display("FAIL nack_code00: got %0d expected 1", sel_nack); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      n_checks++; if (chg_valid !== 1'b1 || chg_coin !== 5'd10) begin
         n_fail++; $display("FAIL cancel_change: got valid %0d coin %0d expected 1 10", chg_valid, chg_coin); end
      ack_change();
      n_checks++; if (credit !== 6'd0 || busy !== 1'b0 || chg_valid !== 1'b0) begin
         n_fail++; $display("FAIL cancel_idle: got credit %0d busy %0d valid %0d expected 0 0 0", credit, busy, chg_valid); end
   endtask

   task automatic test_overflow();
      insert_coin(5'd20);
      insert_coin(5'd20);
      n_checks++; if (credit !== 6'd40) begin n_fail++; $display("FAIL ovf_credit_max: got %0d expected 40", credit); end
      insert_coin(5'd5);
      n_checks++; if (coin_reject !== 1'b1 || coin_accept !== 1'b0) begin
         n_fail++; $display("FAIL ovf_reject: got rej %0d acc %0d expected 1 0", coin_reject, coin_accept); end
      n_checks++; if (credit !== 6'd40) begin n_fail++; $display("FAIL ovf_credit_kept: got %0d expected 40", credit); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      insert_coin(5'd5);
      n_checks++; if (coin_reject !== 1'b1 || credit !== 6'd40) begin
         n_fail++; $display("FAIL chg_coin_reject: got rej %0d credit %0d expected 1 40", coin_reject, credit); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (chg_valid !== 1'b1 || chg_coin !== 5'd10) begin
            n_fail++; $display("FAIL ovf_change_%0d: got valid %0d coin %0d expected 1 10", i, chg_valid, chg_coin); end
         ack_change();
      end
      n_checks++; if (credit !== 6'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL ovf_idle: got credit %0d busy %0d expected 0 0", credit, busy); end
      insert_coin(5'd7);
      n_checks++; if (coin_reject !== 1'b1 || busy !== 1'b0 || credit !== 6'd0) begin
         n_fail++; $display("FAIL illegal_coin: got rej %0d busy %0d credit %0d expected 1 0 0", coin_reject, busy, credit); end
   endtask

   task automatic test_timeout();
      int early;
      insert_coin(5'd10);
      early = 0;
      for (int i = 0; i < 999; i++) begin
         tick();
         if (chg_valid === 1'b1) early++;
      end
      n_checks++; if (early != 0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL tmo_early: got %0d early cycles busy %0d expected 0 1", early, busy); end
      tick();
      n_checks++; if (chg_valid !== 1'b1 || chg_coin !== 5'd10) begin
         n_fail++; $display("FAIL tmo_refund: got valid %0d coin %0d expected 1 10", chg_valid, chg_coin); end
      ack_change();
      n_checks++; if (busy !== 1'b0 || credit !== 6'd0) begin
         n_fail++; $display("FAIL tmo_idle: got busy %0d credit %0d expected 0 0", busy, credit); end
   endtask

   task automatic test_reset_dispense();
      insert_coin(5'd10);
      select(2'b10);
      n_checks++; if (disp_req !== 1'b1 || disp_product !== 2'b10) begin
         n_fail++; $display("FAIL rdisp_req: got req %0d prod %b expected 1 10", disp_req, disp_product); end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (disp_req !== 1'b0 || credit !== 6'd0 || busy !== 1'b0 || disp_product !== 2'b00) begin
         n_fail++; $display("FAIL rdisp_cleared: got req %0d credit %0d busy %0d prod %b expected 0 0 0 00",
                            disp_req, credit, busy, disp_product); end
      tick();
   endtask

   task automatic test_stock();
      insert_coin(5'd5);
      select(2'b01);
      n_checks++; if (disp_req !== 1'b1 || credit !== 6'd0) begin
         n_fail++; $display("FAIL stock_buy1: got req %0d credit %0d expected 1 0", disp_req, credit); end
      disp_done = 1'b1;
      tick();
      disp_done = 1'b0;
      n_checks++; if (busy !== 1'b0 || chg_valid !== 1'b0 || disp_req !== 1'b0) begin
         n_fail++; $display("FAIL stock_idle_no_change: got busy %0d valid %0d req %0d expected 0 0 0", busy, chg_valid, disp_req); end
      insert_coin(5'd5);
      select(2'b01);
`ifdef VEND_INVENTORY_EN
      n_checks++; if (sel_nack !== 1'b1 || credit !== 6'd5 || disp_req !== 1'b0) begin
         n_fail++; $display("FAIL stock_empty_nack: got nack %0d credit %0d req %0d expected 1 5 0", sel_nack, credit, disp_req); end
      n_checks++; if (sold_out !== 3'b001) begin n_fail++; $display("FAIL stock_sold_out: got %b expected 001", sold_out); end
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      ack_change();
`else
      n_checks++; if (sel_nack !== 1'b0 || disp_req !== 1'b1 || credit !== 6'd0) begin
         n_fail++; $display("FAIL stock_unlimited: got nack %0d req %0d credit %0d expected 0 1 0", sel_nack, disp_req, credit); end
      n_checks++; if (sold_out !== 3'b000) begin n_fail++; $display("FAIL stock_sold_out: got %b expected 000", sold_out); end
      disp_done = 1'b1;
      tick();
      disp_done = 1'b0;
`endif
      n_checks++; if (busy !== 1'b0 || credit !== 6'd0) begin
         n_fail++; $display("FAIL stock_end_idle: got busy %0d credit %0d expected 0 0", busy, credit); end
   endtask

   initial begin
      test_reset();
      test_purchase();
      test_nack_cancel();
      test_overflow();
      test_timeout();
      test_reset_dispense();
      test_stock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
